osd_ram_write_sched: RTL
========================

// Module: osd_ram_write_sched
// PURPOSE
// - Schedules the single OSD character-RAM write port between two requesters: I2C register writes and a fill/clear engine.
// - I2C writes come from the I2C register interface (ram_wren/ram_wraddress/ram_dataIn). They cannot be stalled, so they pass through a small FIFO.
// - The fill engine writes one character over a contiguous address range, e.g. OSD clear screen or line blanking.
// - Sits between the I2C register interface and the OSD RAM write port.
// PARAMETERS
// - ADDR_W      10  RAM address width. Addresses wrap modulo 2**ADDR_W.
// - DATA_W      8   RAM data width.
// - FIFO_DEPTH  4   I2C write FIFO entries. Must be a power of two, >= 2.
// PORTS
// - clk            in   1           system clock
// - reset          in   1           asynchronous, active-high reset
// - wr_req         in   1           I2C write strobe, 1-cycle pulse per byte
// - wr_addr        in   ADDR_W      I2C write address, valid with wr_req
// - wr_data        in   DATA_W      I2C write data, valid with wr_req
// - fill_start     in   1           start fill; ignored while fill_busy
// - fill_base      in   ADDR_W      first fill address, sampled on fill_start
// - fill_len       in   ADDR_W+1    number of fill writes, 0..2**ADDR_W, sampled on fill_start
// - fill_char      in   DATA_W      fill value, sampled on fill_start
// - fill_abort     in   1           stop an active fill after the current cycle
// - ram_ready      in   1           RAM port free this cycle; when low, no write is issued
// - ram_wren       out  1           RAM write enable, registered
// - ram_wraddress  out  ADDR_W      RAM write address, registered
// - ram_dataIn     out  DATA_W      RAM write data, registered
// - fill_busy      out  1           fill FSM not IDLE
// - fill_done      out  1           1-cycle pulse when a fill completes or is aborted
// - fifo_level     out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// - overflow       out  1           sticky flag: an I2C write was dropped because the FIFO was full
// - overflow_clr   in   1           clears overflow; a set in the same cycle wins
// BEHAVIOUR
// - Reset values: all outputs 0; FIFO empty; FSM in IDLE; fill counters 0.
// - FIFO push on wr_req.
//   - When full, a push succeeds only if a pop occurs in the same cycle.
//   - Otherwise the write is dropped and overflow is set.
// - FIFO order is strict; data is never reordered.
// - Grant is evaluated each cycle with ram_ready=1.
//   - Candidates: FIFO head (if not empty) and fill (if state is FILL).
//   - The granted write appears on ram_* on the next edge. ram_wren is high for exactly that one cycle.
//   - When ram_ready=0, there is no grant, ram_wren=0 next cycle, and all state holds.
// - Latency: wr_req at cycle N into an empty FIFO with ram_ready high gives ram_wren=1 during cycle N+2.
//   - Push at edge N+1, grant at N+1, registered at edge N+2.
// - Fill FSM states: IDLE -> FILL -> DONE -> IDLE.
//   - IDLE: fill_start latches base, len, and char.
//     - len=0 goes directly to DONE.
//     - Otherwise goes to FILL with addr=base and remaining=len.
//   - FILL: on each fill grant, addr <= addr+1 (wraps modulo 2**ADDR_W) and remaining <= remaining-1.
//     - The grant that takes remaining to 0 moves the FSM to DONE.
//   - fill_abort in FILL moves the FSM to DONE. No fill grant is given in that cycle.
//   - DONE: fill_done=1 for one cycle, then IDLE.
//   - fill_start in FILL or DONE is ignored; there is no queueing.
// - fill_len = 2**ADDR_W writes the whole RAM exactly once. The start address is also the last address + 1.
// - Asynchronous reset mid-fill or mid-write: writes are lost, FIFO is emptied, no fill_done pulse.
// CONFIGURATION
// - OSD_WR_ROUNDROBIN_EN undefined: fixed priority. The FIFO head always wins over fill.
//   - Fill progresses only in cycles when the FIFO is empty.
// - OSD_WR_ROUNDROBIN_EN defined: when both requesters compete, the grant alternates via a 1-bit last-grant flag.
//   - Reset value of the flag is "fill", so the FIFO wins the first conflict.
//   - A lone requester is always granted.
// TESTING
// - Three wr_req pulses in consecutive cycles (addr 0x005/0x006/0x007, data 0x41/0x42/0x43), ram_ready=1
//   -> three consecutive ram_wren cycles in order, the first 2 cycles after the first wr_req. fifo_level peaks at 1.
// - fill_start base=0x3FE len=4 char=0x20, no I2C traffic
//   -> writes to 0x3FE, 0x3FF, 0x000, 0x001, then one fill_done pulse, then fill_busy=0.
// - ram_ready held 0, five wr_req with FIFO_DEPTH=4
//   -> fifo_level=4, overflow=1, fifth write absent.
//   - Then ram_ready=1 -> exactly four ram_wren; overflow stays 1 until overflow_clr.
// - Fill len=8 with one wr_req in mid-fill
//   - Without the macro: the I2C write interrupts the fill for 1 cycle, 9 writes total.
//   - With the macro: same count, and no requester is granted twice in a row while both are pending.
// - fill_abort on the 3rd fill cycle -> exactly 2 fill writes, fill_done pulses once. fill_start in the next cycle is accepted.
// - Assert reset while FILL and FIFO non-empty
//   -> ram_wren=0, fill_busy=0, fifo_level=0 immediately (asynchronous), no fill_done.

Source files
------------

// File: rtl/osd_ram_write_sched.sv
// Arbitrates the single OSD character-RAM write port between buffered I2C register
// writes and a fill/clear engine that writes one character over an address range.
// Optional macro OSD_WR_ROUNDROBIN_EN: alternate grants on conflict instead of
// giving the I2C FIFO fixed priority over the fill engine.
`timescale 1ns/1ps
module osd_ram_write_sched #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wr_req,
    input  logic [ADDR_W-1:0]               wr_addr,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic                            fill_start,
    input  logic [ADDR_W-1:0]               fill_base,
    input  logic [ADDR_W:0]                 fill_len,
    input  logic [DATA_W-1:0]               fill_char,
    input  logic                            fill_abort,
    input  logic                            ram_ready,
    output logic                            ram_wren,
    output logic [ADDR_W-1:0]               ram_wraddress,
    output logic [DATA_W-1:0]               ram_dataIn,
    output logic                            fill_busy,
    output logic                            fill_done,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    input  logic                            overflow_clr
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StFill, StDone} fill_state_e;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  count_q;
    logic              overflow_q;
    logic              fifo_empty, fifo_full, push, pop;

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [ADDR_W:0]   fill_rem_q, fill_rem_d;
    logic [DATA_W-1:0] fill_ch_q, fill_ch_d;

    logic              fifo_req, fill_req, gnt_fifo, gnt_fill;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == LVL_W'(FIFO_DEPTH));
    assign fifo_req   = !fifo_empty;
    // An abort cycle never carries a fill write.
    assign fill_req   = (state_q == StFill) && !fill_abort;
    assign pop        = gnt_fifo;
    // A full FIFO still accepts a write when its head leaves in the same cycle.
    assign push       = wr_req && (!fifo_full || pop);

`ifdef OSD_WR_ROUNDROBIN_EN
    logic last_fifo_q;  // 1: last grant went to the FIFO; reset to "fill" so FIFO wins first

    // Grant: alternate on conflict, lone requester always wins.
    always_comb begin
        gnt_fifo = ram_ready && fifo_req && (!fill_req || !last_fifo_q);
        gnt_fill = ram_ready && fill_req && (!fifo_req || last_fifo_q);
    end

    // Remember which requester was served last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_fifo_q <= 1'b0;
        end else if (gnt_fifo) begin
            last_fifo_q <= 1'b1;
        end else if (gnt_fill) begin
            last_fifo_q <= 1'b0;
        end
    end
`else
    // Grant: FIFO head always beats the fill engine.
    always_comb begin
        gnt_fifo = ram_ready && fifo_req;
        gnt_fill = ram_ready && fill_req && !fifo_req;
    end
`endif

    // FIFO storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= wr_addr;
            fifo_data[wr_ptr_q] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + LVL_W'(push) - LVL_W'(pop);
            if (wr_req && !push) begin
                overflow_q <= 1'b1;
            end else if (overflow_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Fill FSM next state and counters.
    always_comb begin
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        fill_rem_d  = fill_rem_q;
        fill_ch_d   = fill_ch_q;
        unique case (state_q)
            StIdle: begin
                if (fill_start) begin
                    fill_addr_d = fill_base;
                    fill_rem_d  = fill_len;
                    fill_ch_d   = fill_char;
                    state_d     = (fill_len == '0) ? StDone : StFill;
                end
            end
            StFill: begin
                if (fill_abort) begin
                    state_d = StDone;
                end else if (gnt_fill) begin
                    fill_addr_d = fill_addr_q + ADDR_W'(1);
                    fill_rem_d  = fill_rem_q - (ADDR_W+1)'(1);
                    if (fill_rem_q == (ADDR_W+1)'(1)) state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Fill FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            fill_addr_q <= '0;
            fill_rem_q  <= '0;
            fill_ch_q   <= '0;
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            fill_rem_q  <= fill_rem_d;
            fill_ch_q   <= fill_ch_d;
        end
    end

    // Registered RAM write port; address/data hold when no write is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_wren      <= 1'b0;
            ram_wraddress <= '0;
            ram_dataIn    <= '0;
        end else begin
            ram_wren <= gnt_fifo || gnt_fill;
            if (gnt_fifo) begin
                ram_wraddress <= fifo_addr[rd_ptr_q];
                ram_dataIn    <= fifo_data[rd_ptr_q];
            end else if (gnt_fill) begin
                ram_wraddress <= fill_addr_q;
                ram_dataIn    <= fill_ch_q;
            end
        end
    end

    assign fill_busy  = (state_q != StIdle);
    assign fill_done  = (state_q == StDone);
    assign fifo_level = count_q;
    assign overflow   = overflow_q;

endmodule
